// File: rtl/aes_model_pack.sv
// Shared AES model constants and the byte-oriented block type.
// byte_table index 15 is the most significant byte of the flattened 128-bit value.
package aes_model_pack;

    localparam int BLOCK_SIZE = 128;
    localparam int CLK_FREQ   = 100_000_000;

    typedef logic [15:0][7:0] byte_table;

endpackage

// File: rtl/key_and_sync_ctrl_pkg.sv
// Types local to the key/sync controller: upstream word layout and load-state encoding.
package key_and_sync_ctrl_pkg;
    import aes_model_pack::*;

    localparam int STREAM_W = 2 * BLOCK_SIZE;

    // Upstream word: key occupies the upper half, sync the lower half.
    typedef struct packed {
        byte_table key;
        byte_table sync;
    } key_sync_t;

    typedef enum logic {
        KS_EMPTY  = 1'b0,
        KS_LOADED = 1'b1
    } ks_state_t;

endpackage

// File: rtl/dvr_if.sv
// Data/valid/ready stream interface; transfer occurs on a rising clk edge with valid & ready.
interface dvr_if #(
    parameter int W = 256
) (
    input logic clk
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (input clk, output data, output valid, input ready);
    modport slave  (input clk, input data, input valid, output ready);
endinterface

// File: rtl/sync_counter.sv
// Loadable W-bit incrementer; load beats increment, wrap pulses with the wrapped value.
// Latency 1 cycle for load and increment; no backpressure.
module sync_counter #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                value <= load_val;
            end else if (inc) begin
                value <= value + ONE;
                wrap  <= &value;
            end
        end
    end

endmodule

// File: rtl/key_and_sync_ctrl.sv
// Holds AES session key and sync; loads {key,sync} on request, advances sync on pulse.
// Latency 1 cycle for load/increment; ready = req while out of reset, no internal buffering.
module key_and_sync_ctrl
    import aes_model_pack::*;
    import key_and_sync_ctrl_pkg::*;
#(
    parameter int BLOCK_SIZE = aes_model_pack::BLOCK_SIZE
) (
    input  logic      clk,
    input  logic      rst,
    dvr_if.slave      key_and_sync_in,
    input  logic      key_and_sync_req,
    input  logic      new_sync_req,
    output logic      key_and_sync_vld,
    output byte_table key,
    output byte_table sync,
    output logic      sync_overlapse_irq
);

    ks_state_t state;
    ks_state_t state_next;
    key_sync_t word;
    logic      handshake;
    logic      inc_en;

    assign key_and_sync_in.ready = key_and_sync_req & rst;
    assign handshake             = key_and_sync_in.valid & key_and_sync_in.ready;
    assign word                  = key_and_sync_in.data;

    // A pending request invalidates the current pair until the new one arrives.
    always_comb begin
        state_next       = state;
        key_and_sync_vld = (state == KS_LOADED);
        if (handshake) begin
            state_next = KS_LOADED;
        end else if (key_and_sync_req) begin
            state_next = KS_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= KS_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key <= '0;
        end else if (handshake) begin
            key <= word.key;
        end
    end

    assign inc_en = new_sync_req & key_and_sync_vld & ~handshake;

    sync_counter #(
        .W (BLOCK_SIZE)
    ) u_sync_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (handshake),
        .load_val (word.sync),
        .inc      (inc_en),
        .value    (sync),
        .wrap     (sync_overlapse_irq)
    );

endmodule

// File: tb/tb_key_and_sync_ctrl.sv
module tb_key_and_sync_ctrl;
    import aes_model_pack::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      key_and_sync_req;
    logic      new_sync_req;
    logic      key_and_sync_vld;
    byte_table key;
    byte_table sync;
    logic      sync_overlapse_irq;

    int checks = 0;
    int errors = 0;

    logic [127:0] all_ones;

    always #5 clk = ~clk;

    dvr_if #(.W(256)) ks_if (.clk(clk));

    key_and_sync_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .key_and_sync_in    (ks_if),
        .key_and_sync_req   (key_and_sync_req),
        .new_sync_req       (new_sync_req),
        .key_and_sync_vld   (key_and_sync_vld),
        .key                (key),
        .sync               (sync),
        .sync_overlapse_irq (sync_overlapse_irq)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [127:0] ek, input logic [127:0] es,
                               input logic ev, input logic ei);
        check({tag, "_key"},  key, ek);
        check({tag, "_sync"}, sync, es);
        check({tag, "_vld"},  {127'd0, key_and_sync_vld}, {127'd0, ev});
        check({tag, "_irq"},  {127'd0, sync_overlapse_irq}, {127'd0, ei});
    endtask

    initial begin
        all_ones         = '1;
        rst              = 1'b0;
        key_and_sync_req = 1'b0;
        new_sync_req     = 1'b0;
        ks_if.valid      = 1'b0;
        ks_if.data       = '0;

        // Reset state, including ready masked while in reset
        tick();
        key_and_sync_req = 1'b1;
        #1;
        check("rst_ready", {127'd0, ks_if.ready}, 128'd0);
        key_and_sync_req = 1'b0;
        tick();
        check_state("reset", 128'd0, 128'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_state("post_rst", 128'd0, 128'd0, 1'b0, 1'b0);

        // Increment before any load is ignored
        new_sync_req = 1'b1;
        tick();
        new_sync_req = 1'b0;
        check_state("inc_noload", 128'd0, 128'd0, 1'b0, 1'b0);

        // First load
        key_and_sync_req = 1'b1;
        ks_if.valid      = 1'b1;
        ks_if.data       = {128'h1, 128'h1};
        #1;
        check("load_ready", {127'd0, ks_if.ready}, 128'd1);
        tick();
        key_and_sync_req = 1'b0;
        ks_if.valid      = 1'b0;
        #1;
        check("ready_drop", {127'd0, ks_if.ready}, 128'd0);
        check_state("load1", 128'h1, 128'h1, 1'b1, 1'b0);

        // Single increment
        new_sync_req = 1'b1;
        tick();
        new_sync_req = 1'b0;
        check_state("inc1", 128'h1, 128'h2, 1'b1, 1'b0);

        // Valid without request is not sampled
        ks_if.valid = 1'b1;
        ks_if.data  = {128'd77, 128'd77};
        tick();
        ks_if.valid = 1'b0;
        check_state("no_req", 128'h1, 128'h2, 1'b1, 1'b0);

        // Request pending without data: vld drops, old values held, increments ignored
        key_and_sync_req = 1'b1;
        tick();
        check_state("req_wait", 128'h1, 128'h2, 1'b0, 1'b0);
        new_sync_req = 1'b1;
        tick();
        new_sync_req = 1'b0;
        check_state("req_inc", 128'h1, 128'h2, 1'b0, 1'b0);
        ks_if.valid = 1'b1;
        ks_if.data  = {128'd102, 128'd412};
        tick();
        key_and_sync_req = 1'b0;
        ks_if.valid      = 1'b0;
        check_state("reload", 128'd102, 128'd412, 1'b1, 1'b0);

        // Held request gives one increment per cycle
        new_sync_req = 1'b1;
        tick();
        check("burst1", sync, 128'd413);
        tick();
        check("burst2", sync, 128'd414);
        tick();
        new_sync_req = 1'b0;
        check("burst3", sync, 128'd415);

        // Wrap from all-ones
        key_and_sync_req = 1'b1;
        ks_if.valid      = 1'b1;
        ks_if.data       = {128'hAB, all_ones};
        tick();
        key_and_sync_req = 1'b0;
        ks_if.valid      = 1'b0;
        check_state("load_ones", 128'hAB, all_ones, 1'b1, 1'b0);
        new_sync_req = 1'b1;
        tick();
        new_sync_req = 1'b0;
        check_state("wrap", 128'hAB, 128'd0, 1'b1, 1'b1);
        tick();
        check_state("wrap_after", 128'hAB, 128'd0, 1'b1, 1'b0);

        // Load wins over simultaneous increment, even from all-ones
        key_and_sync_req = 1'b1;
        ks_if.valid      = 1'b1;
        ks_if.data       = {128'hCD, all_ones};
        tick();
        ks_if.data       = {128'd9, 128'd5};
        new_sync_req     = 1'b1;
        tick();
        key_and_sync_req = 1'b0;
        ks_if.valid      = 1'b0;
        new_sync_req     = 1'b0;
        check_state("prio", 128'd9, 128'd5, 1'b1, 1'b0);

        // Asynchronous reset mid-operation
        #2;
        rst = 1'b0;
        #1;
        check_state("async_rst", 128'd0, 128'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        new_sync_req = 1'b1;
        tick();
        new_sync_req = 1'b0;
        check_state("rst_then_inc", 128'd0, 128'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
